dpram_sample_fifo: RTL and testbench

DPRAM_SAMPLE_FIFO -- requirements
Module: dpram_sample_fifo

---
 rtl/dpram_sample_fifo.sv | 165 ++++++++++++++++
 tb/tb_dpram_sample_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dpram_sample_fifo.sv
// dpram_sample_fifo
//   Dual-use sample buffer for the J1 processor. In RAM mode the J1 reads and
//   writes the DEPTH-word memory directly. In FIFO mode the acquisition front
//   end pushes samples through a valid/ready port. The J1 pops them through the
//   DATA register and can still peek the memory through the RAM window.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   cs, addr, rd,   J1 I/O bus: addr MSB=0 selects the RAM window,
//   wr, d_in, d_out MSB=1 selects registers by addr[1:0]; d_out is registered
//   s_valid,        producer sample handshake (FIFO mode only)
//   s_data, s_ready
//   irq             registered interrupt: irq_en && (almost_full || overflow)
//
// Register map (addr MSB = 1)
//   0 DATA   RO   pop one word (FIFO mode); 0 and underflow when empty
//   1 STATUS W1C  {underflow, overflow, almost_full, full, empty}
//   2 CTRL   RW   {irq_en, flush (reads 0), mode}
//   3 COUNT  RO   fill level, zero-extended
module dpram_sample_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int AFULL_LVL = 192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [ADDR_W:0]   addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              irq
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_LVL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              mode;
  logic              irq_en;
  logic              overflow;
  logic              underflow;

  logic              empty;
  logic              full;
  logic              afull;
  logic              reg_sel;
  logic [ADDR_W-1:0] ram_a;
  logic              wr_en;
  logic              rd_en;
  logic              data_rd;
  logic              pop;
  logic              under;
  logic              push;
  logic              over;
  logic              ctrl_wr;
  logic              stat_wr;
  logic              ram_wr;
  logic              clr;
  logic [DATA_W-1:0] rd_data;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign afull   = (count >= AFULL_C);
  assign s_ready = mode && !full;

  assign reg_sel = addr[ADDR_W];
  assign ram_a   = addr[ADDR_W-1:0];

  // A write always wins over a simultaneous read strobe.
  assign wr_en   = cs && wr;
  assign rd_en   = cs && rd && !wr;

  assign data_rd = rd_en && reg_sel && (addr[1:0] == 2'd0);
  // Pop and underflow look at the count before the edge, so a push into an
  // empty FIFO in the same cycle still reports underflow.
  assign pop     = data_rd && mode && !empty;
  assign under   = data_rd && mode && empty;
  assign push    = mode && s_valid && !full;
  assign over    = mode && s_valid && full;

  assign ctrl_wr = wr_en && reg_sel && (addr[1:0] == 2'd2);
  assign stat_wr = wr_en && reg_sel && (addr[1:0] == 2'd1);
  assign ram_wr  = wr_en && !reg_sel && !mode;
  // Flush bit, or any change of mode, restarts the FIFO from an empty state.
  assign clr     = ctrl_wr && (d_in[1] || (d_in[0] != mode));

  always_comb begin
    rd_data = '0;
    if (!reg_sel) begin
      rd_data = mem[ram_a];
    end else begin
      case (addr[1:0])
        2'd0:    if (mode && !empty) rd_data = mem[rd_ptr];
        2'd1:    rd_data = DATA_W'({underflow, overflow, afull, full, empty});
        2'd2:    rd_data = DATA_W'({irq_en, 1'b0, mode});
        default: rd_data = DATA_W'(count);
      endcase
    end
  end

  // RAM writes come only from the J1 in RAM mode and only from the producer in
  // FIFO mode, so one write port serves both. Memory is not reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[ram_a] <= d_in;
    end else if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mode      <= 1'b0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (rd_en) d_out <= rd_data;

      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        mode   <= d_in[0];
        irq_en <= d_in[2];
      end

      // A new event in the same cycle as a clear keeps the flag set.
      if (over) overflow <= 1'b1;
      else if (stat_wr && d_in[3]) overflow <= 1'b0;

      if (under) underflow <= 1'b1;
      else if (stat_wr && d_in[4]) underflow <= 1'b0;

      irq <= irq_en && (afull || overflow);
    end
  end

endmodule

// File: tb/tb_dpram_sample_fifo.sv
// Bench for dpram_sample_fifo: J1 reads push their expected value onto a
// scoreboard queue; the value is popped and compared with d_out once the read
// response is due. FIFO contents are tracked by a simple reference queue.
module tb_dpram_sample_fifo;
  localparam int DEPTH = 256;
  localparam logic [8:0] A_DATA = 9'h100;
  localparam logic [8:0] A_STAT = 9'h101;
  localparam logic [8:0] A_CTRL = 9'h102;
  localparam logic [8:0] A_CNT  = 9'h103;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [8:0]  addr = '0;
  logic [15:0] d_in = '0;
  logic [15:0] d_out;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb_q[$];
  logic [15:0] mq[$];

  dpram_sample_fifo #(.DATA_W(16), .ADDR_W(8), .AFULL_LVL(192)) dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_in(d_in), .d_out(d_out), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle, entered and left at a falling edge.
  task automatic cyc(input logic c_rd, input logic c_wr, input logic [8:0] a,
                     input logic [15:0] d, input logic sv, input logic [15:0] sd,
                     input logic [15:0] exp, input string tag);
    cs = c_rd | c_wr; rd = c_rd; wr = c_wr; addr = a; d_in = d;
    s_valid = sv; s_data = sd;
    if (c_rd) sb_q.push_back(exp);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0; s_valid = 1'b0;
    if (c_rd) chk(tag, 32'(d_out), 32'(sb_q.pop_front()));
  endtask

  task automatic wr_reg(input logic [8:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 16'h0, 16'h0, "");
  endtask

  task automatic rd_chk(input logic [8:0] a, input logic [15:0] exp, input string tag);
    cyc(1'b1, 1'b0, a, 16'h0, 1'b0, 16'h0, exp, tag);
  endtask

  task automatic push(input logic [15:0] v);
    if (mq.size() < DEPTH) mq.push_back(v);
    cyc(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, v, 16'h0, "");
  endtask

  task automatic pop(input string tag);
    logic [15:0] exp;
    exp = (mq.size() > 0) ? mq.pop_front() : 16'h0;
    rd_chk(A_DATA, exp, tag);
  endtask

  // Push and DATA read in the same cycle; the pop sees the pre-edge contents.
  task automatic push_pop(input logic [15:0] v, input string tag);
    logic [15:0] exp;
    logic        acc;
    acc = (mq.size() < DEPTH);
    exp = (mq.size() > 0) ? mq.pop_front() : 16'h0;
    if (acc) mq.push_back(v);
    cyc(1'b1, 1'b0, A_DATA, 16'h0, 1'b1, v, exp, tag);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_d_out", 32'(d_out), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    @(negedge clk);

    rd_chk(A_CTRL, 16'h0000, "ctrl_reset");
    rd_chk(A_CNT,  16'h0000, "count_reset");
    rd_chk(A_STAT, 16'h0001, "status_reset");

    // RAM mode
    wr_reg(9'h005, 16'hA5A5);
    wr_reg(9'h010, 16'h1234);
    wr_reg(9'h0FF, 16'hBEEF);
    rd_chk(9'h005, 16'hA5A5, "ram_005");
    rd_chk(9'h010, 16'h1234, "ram_010");
    rd_chk(9'h0FF, 16'hBEEF, "ram_0ff");
    wr_reg(9'h020, 16'h4321);
    chk("d_out_hold", 32'(d_out), 32'hBEEF);
    cyc(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, 16'h5555, 16'h0, "");
    chk("ram_s_ready", 32'(s_ready), 0);
    rd_chk(A_CNT, 16'h0000, "ram_no_push");

    // FIFO mode, basic
    wr_reg(A_CTRL, 16'h0001);
    mq.delete();
    chk("fifo_s_ready", 32'(s_ready), 1);
    for (int i = 1; i <= 3; i++) push(16'(i));
    rd_chk(A_CNT, 16'd3, "count_3");
    for (int i = 0; i < 3; i++) pop("pop_123");
    rd_chk(A_STAT, 16'h0001, "empty_after_pops");

    // Underflow and W1C
    pop("underflow_data");
    rd_chk(A_STAT, 16'h0011, "underflow_set");
    wr_reg(A_STAT, 16'h0010);
    rd_chk(A_STAT, 16'h0001, "underflow_clr");

    // Peek and ignored RAM-window write in FIFO mode
    rd_chk(9'h001, 16'h0002, "peek_1");
    wr_reg(9'h001, 16'hDEAD);
    rd_chk(9'h001, 16'h0002, "peek_after_wr");
    rd_chk(A_CNT, 16'h0000, "peek_no_ptr");

    // Fill to full with irq enabled
    wr_reg(A_CTRL, 16'h0005);
    for (int k = 1; k <= DEPTH; k++) begin
      push(16'h1000 + 16'(k));
      if (k == 192) chk("irq_at_192", 32'(irq), 0);
      if (k == 193) chk("irq_at_193", 32'(irq), 1);
    end
    chk("full_s_ready", 32'(s_ready), 0);
    rd_chk(A_STAT, 16'h0006, "status_full");
    push(16'hFFFF);
    rd_chk(A_STAT, 16'h000E, "status_overflow");
    rd_chk(A_CNT, 16'h0100, "count_256");
    chk("irq_full", 32'(irq), 1);
    for (int k = 0; k < DEPTH; k++) pop("drain");
    rd_chk(A_CNT, 16'h0000, "count_drained");
    chk("irq_ovf", 32'(irq), 1);

    // Flush keeps sticky flags
    wr_reg(A_CTRL, 16'h0007);
    mq.delete();
    rd_chk(A_CTRL, 16'h0005, "ctrl_flush_reads0");
    rd_chk(A_STAT, 16'h0009, "flush_keeps_ovf");
    wr_reg(A_STAT, 16'h0008);
    rd_chk(A_STAT, 16'h0001, "ovf_clr");
    chk("irq_clr", 32'(irq), 0);

    // Pointer wrap with simultaneous push and pop
    for (int k = 0; k < 255; k++) push(16'h2000 + 16'(k));
    for (int k = 0; k < 255; k++) pop("pre_wrap");
    push(16'h7777);
    push_pop(16'h8888, "wrap_pop");
    rd_chk(A_CNT, 16'h0001, "wrap_count");
    rd_chk(9'h000, 16'h8888, "wrap_wr_ptr0");
    pop("wrap_rd_ptr0");

    // Push into empty with a same-cycle pop
    push_pop(16'h9999, "empty_push_pop");
    rd_chk(A_CNT, 16'h0001, "epp_count");
    rd_chk(A_STAT, 16'h0010, "epp_underflow");
    pop("epp_data");
    wr_reg(A_STAT, 16'h0010);

    // Reset mid-stream with a read in flight
    for (int k = 0; k < 10; k++) push(16'h0A00 + 16'(k));
    rd_chk(A_CNT, 16'd10, "count_10");
    cs = 1'b1; rd = 1'b1; addr = A_DATA; s_valid = 1'b1; s_data = 16'hFFFF;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_d_out", 32'(d_out), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; s_valid = 1'b0; rst = 1'b0;
    mq.delete();
    @(negedge clk);
    chk("post_rst_d_out", 32'(d_out), 0);
    rd_chk(A_CNT, 16'h0000, "post_rst_count");
    rd_chk(A_CTRL, 16'h0000, "post_rst_ctrl");
    chk("post_rst_s_ready", 32'(s_ready), 0);
    rd_chk(9'h002, 16'h0A00, "mem_kept_2");
    rd_chk(9'h00B, 16'h0A09, "mem_kept_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
